alu_flag_stage: RTL

//  - Registered output stage directly downstream of the 4-bit ripple-carry adder.
//  - Captures the adder sum, carry-out and MSB carry-in, and derives N/Z/C/V flags.
//  - Presents result+flags over a valid/ready handshake through a 2-entry FIFO (skid buffer).
//  - Provides back-pressure decoupling between the ALU datapath and its consumer.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_flag_calc.sv | 22 ++
 rtl/alu_flag_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage: flag bit positions and FIFO fill states.
package alu_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fillState_e;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational flag derivation from the ripple-carry adder outputs: {N,Z,C,V}.
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  sum_i,
    input  logic              cout_i,
    input  logic              cmsb_i,
    output logic [FLAG_W-1:0] flags_o
);

    // Overflow is a carry into the MSB that did not carry out, or vice versa.
    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = sum_i[WIDTH-1];
        flags_o[FLAG_Z] = (sum_i == '0);
        flags_o[FLAG_C] = cout_i;
        flags_o[FLAG_V] = cout_i ^ cmsb_i;
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result+flag stage behind the 4-bit adder, a 2-entry valid/ready skid FIFO.
// Define ALU_STICKY_OVF_EN to add the sticky overflow register (ovf_sticky/ovf_clr).
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_sum,
    input  logic              in_cout,
    input  logic              in_cmsb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              ovf_clr,
    output logic              ovf_sticky
);

    fillState_e        fill_q, fill_d;
    logic [WIDTH-1:0]  headResult_q, headResult_d;
    logic [WIDTH-1:0]  tailResult_q, tailResult_d;
    logic [FLAG_W-1:0] headFlags_q, headFlags_d;
    logic [FLAG_W-1:0] tailFlags_q, tailFlags_d;
    logic [FLAG_W-1:0] newFlags;
    logic              push;
    logic              pop;

    alu_flag_calc #(.WIDTH(WIDTH)) uFlagCalc (
        .sum_i   (in_sum),
        .cout_i  (in_cout),
        .cmsb_i  (in_cmsb),
        .flags_o (newFlags)
    );

    assign in_ready   = rst_n && (fill_q != FILL_FULL);
    assign out_valid  = (fill_q != FILL_EMPTY);
    assign out_result = headResult_q;
    assign out_flags  = headFlags_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // The head slot drives the outputs directly; vacated slots are zeroed.
    always_comb begin
        fill_d       = fill_q;
        headResult_d = headResult_q;
        headFlags_d  = headFlags_q;
        tailResult_d = tailResult_q;
        tailFlags_d  = tailFlags_q;
        case (fill_q)
            FILL_EMPTY: begin
                if (push) begin
                    headResult_d = in_sum;
                    headFlags_d  = newFlags;
                    fill_d       = FILL_ONE;
                end
            end
            FILL_ONE: begin
                if (push && pop) begin
                    headResult_d = in_sum;
                    headFlags_d  = newFlags;
                end else if (push) begin
                    tailResult_d = in_sum;
                    tailFlags_d  = newFlags;
                    fill_d       = FILL_FULL;
                end else if (pop) begin
                    headResult_d = '0;
                    headFlags_d  = '0;
                    fill_d       = FILL_EMPTY;
                end
            end
            FILL_FULL: begin
                if (pop) begin
                    headResult_d = tailResult_q;
                    headFlags_d  = tailFlags_q;
                    tailResult_d = '0;
                    tailFlags_d  = '0;
                    fill_d       = FILL_ONE;
                end
            end
            default: begin
                fill_d       = FILL_EMPTY;
                headResult_d = '0;
                headFlags_d  = '0;
                tailResult_d = '0;
                tailFlags_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q       <= FILL_EMPTY;
            headResult_q <= '0;
            headFlags_q  <= '0;
            tailResult_q <= '0;
            tailFlags_q  <= '0;
        end else begin
            fill_q       <= fill_d;
            headResult_q <= headResult_d;
            headFlags_q  <= headFlags_d;
            tailResult_q <= tailResult_d;
            tailFlags_q  <= tailFlags_d;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic ovfSticky_q;

    // Setting on an overflowing pop takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovfSticky_q <= 1'b0;
        end else if (pop && headFlags_q[FLAG_V]) begin
            ovfSticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovfSticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovfSticky_q;
`else
    logic unusedOvfClr;

    assign unusedOvfClr = ovf_clr;
    assign ovf_sticky   = 1'b0;
`endif

endmodule
